hazard_stall_ctrl: RTL and testbench
====================================

// Module: hazard_stall_ctrl
// PURPOSE
// - Hazard/stall controller for the 5-stage pipeline. Drives the enables of the PC and IF/ID registers and the clear of the ID/EX register.
// - Produces the D-stage forwarding selects for rs and rt.
// - Tracks mult/div unit occupancy with a cycle counter, and counts stall cycles for performance readout.
// - Sits beside the D stage; all inputs come from the D/E/M/W pipeline registers.
// PARAMETERS
// - MULT_CYC     5   busy cycles after a mult/multu issues in E
// - DIV_CYC      10  busy cycles after a div/divu issues in E
// - CNT_W        4   busy counter width; must hold max(MULT_CYC, DIV_CYC)
// - STALL_CNT_W  32  stall performance counter width
// PORTS
// - clk          in   1        clock
// - reset        in   1        synchronous, active-high reset
// - D_rs         in   5        rs index of the instruction in D
// - D_rt         in   5        rt index of the instruction in D
// - D_rs_tuse    in   2        cycles until D needs rs; 3 = rs not read
// - D_rt_tuse    in   2        cycles until D needs rt; 3 = rt not read
// - D_md_use     in   1        D instr is mult/div/mfhi/mflo/mthi/mtlo
// - E_wa         in   5        destination register of the E instr
// - E_regwrite   in   1        E instr writes the register file
// - E_tnew       in   2        cycles until E result is ready
// - E_md_start   in   1        E holds a mult/div this cycle
// - E_md_div     in   1        1 = div/divu, 0 = mult/multu (valid with E_md_start)
// - M_wa         in   5        destination register of the M instr
// - M_regwrite   in   1        M instr writes the register file
// - M_tnew       in   2        cycles until M result is ready
// - W_wa         in   5        destination register of the W instr
// - W_regwrite   in   1        W instr writes the register file
// - stall        out  1        D-stage stall this cycle
// - pc_en        out  1        = ~stall
// - if_id_en     out  1        = ~stall
// - id_ex_clr    out  1        = stall (bubble into E)
// - fwd_rs_sel   out  2        0 = RF, 1 = W, 2 = M, 3 = E
// - fwd_rt_sel   out  2        same encoding as fwd_rs_sel
// - md_busy      out  1        mult/div unit busy (registered)
// - stall_cycles out  STALL_CNT_W  saturating count of stalled cycles
// BEHAVIOUR
// - Reset values: md counter = 0, so md_busy = 0; stall_cycles = 0. While reset = 1, stall is forced to 0, giving pc_en = 1, if_id_en = 1, id_ex_clr = 0.
// - Data stall, per source s in {rs, rt}:
//   - Condition: s != 0 and tuse_s != 3, and either (E_regwrite & E_wa == s & E_tnew > tuse_s) or (M_regwrite & M_wa == s & M_tnew > tuse_s).
//   - Combinational, zero latency.
// - MD stall: D_md_use & (md_busy | E_md_start).
// - stall = data stall | MD stall. pc_en, if_id_en and id_ex_clr derive from it in the same cycle.
// - Forward select, per source s, priority E > M > W:
//   - 3 if E_regwrite & E_wa == s & E_tnew == 0
//   - else 2 if M_regwrite & M_wa == s & M_tnew == 0
//   - else 1 if W_regwrite & W_wa == s
//   - else 0
//   - s == 0 always gives 0.
// - MD counter, updated each posedge:
//   - reset -> 0
//   - else if E_md_start -> load (E_md_div ? DIV_CYC : MULT_CYC)
//   - else if cnt != 0 -> cnt - 1
//   - md_busy = (cnt != 0).
//   - The first busy cycle is the one after E_md_start; busy lasts exactly MULT_CYC or DIV_CYC cycles.
// - Start while busy: a reload wins. This cannot occur in legal flow, since the MD stall blocks it.
// - Reset mid-operation: counter cleared the next edge; no residual stall.
// - stall_cycles increments on every non-reset cycle with stall = 1. It saturates at all-ones and never wraps.
// - A single cycle with both a data stall and an MD stall counts once.
// STRUCTURE
// - Shared package hazard_pkg holds:
//   - TUSE_NONE = 2'd3
//   - FWD_RF / FWD_W / FWD_M / FWD_E codes
//   - MULT_CYC and DIV_CYC defaults
// - One sub-module, md_busy_counter: load/decrement counter with a busy output.
// - Stall and forwarding logic stays in the top module as combinational logic.
// TESTING
// - Load-use: E = lw, E_wa = 8, E_tnew = 2, E_regwrite = 1; D_rs = 8, D_rs_tuse = 1 -> stall = 1, pc_en = 0, id_ex_clr = 1.
// - Same hazard next cycle from M: M_wa = 8, M_tnew = 1, D_rs_tuse = 1 -> stall = 0, fwd_rs_sel = 0. With M_tnew = 0 -> fwd_rs_sel = 2.
// - $0 and unused source: E_wa = 0, D_rs = 0 -> stall = 0, fwd = 0. D_rt_tuse = 3 with E_wa == D_rt -> no stall from rt.
// - Priority: E, M and W all write reg 5 with tnew = 0; D_rt = 5 -> fwd_rt_sel = 3. Drop E -> 2. Drop M -> 1.
// - Div: E_md_start = 1, E_md_div = 1 at cycle t:
//   - md_busy = 1 for cycles t+1 .. t+10, 0 at t+11.
//   - D_md_use held high -> stall at cycles t .. t+10; stall_cycles = 11.
// - Reset at t+3 of a mult -> md_busy = 0 at t+4, stall_cycles = 0. Preload stall_cycles near max with stall held -> holds at all-ones.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared hazard-unit constants, forward-select codes and per-source helper functions.
// Latency: n/a (package only; helpers are purely combinational).
// Backpressure: n/a.
package hazard_pkg;

    // A source whose tuse equals this value is not read by the D instruction.
    localparam logic [1:0] TUSE_NONE = 2'd3;

    // Forward select encoding; higher codes come from younger pipeline stages.
    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_W  = 2'd1,
        FWD_M  = 2'd2,
        FWD_E  = 2'd3
    } fwd_sel_e;

    localparam int MULT_CYC_DEF = 5;
    localparam int DIV_CYC_DEF  = 10;

    // One producer stage cannot deliver src in time: result arrives later than D needs it.
    function automatic logic src_hazard(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic       we,
        input logic [4:0] wa,
        input logic [1:0] tnew
    );
        return (src != 5'd0) && (tuse != TUSE_NONE) && we && (wa == src) && (tnew > tuse);
    endfunction

    // Youngest stage holding a ready value for src wins; $0 always reads the RF.
    function automatic fwd_sel_e fwd_pick(
        input logic [4:0] src,
        input logic       e_we,
        input logic [4:0] e_wa,
        input logic [1:0] e_tnew,
        input logic       m_we,
        input logic [4:0] m_wa,
        input logic [1:0] m_tnew,
        input logic       w_we,
        input logic [4:0] w_wa
    );
        fwd_sel_e sel;
        sel = FWD_RF;
        if (src != 5'd0) begin
            if (e_we && (e_wa == src) && (e_tnew == 2'd0)) begin
                sel = FWD_E;
            end else if (m_we && (m_wa == src) && (m_tnew == 2'd0)) begin
                sel = FWD_M;
            end else if (w_we && (w_wa == src)) begin
                sel = FWD_W;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Mult/div occupancy counter: loads the op length on start, counts down, busy while non-zero.
// Latency: busy rises the cycle after start and stays high for exactly MULT_CYC or DIV_CYC cycles.
// Backpressure: none; a start while busy reloads the counter (the stall logic keeps this out of legal flow).
module md_busy_counter
    import hazard_pkg::*;
#(
    parameter int CNT_W    = 4,
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: a new op reloads, otherwise drain toward zero.
    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = is_div ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register with synchronous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// D-stage hazard unit: data/mult-div stall, pipeline enables, rs/rt forward selects, stall perf counter.
// Latency: stall, enables and forward selects are combinational; md_busy and stall_cycles are registered.
// Backpressure: stall freezes PC and IF/ID and injects a bubble into ID/EX in the same cycle.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int MULT_CYC    = MULT_CYC_DEF,
    parameter int DIV_CYC     = DIV_CYC_DEF,
    parameter int CNT_W       = 4,
    parameter int STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [4:0]             D_rs,
    input  logic [4:0]             D_rt,
    input  logic [1:0]             D_rs_tuse,
    input  logic [1:0]             D_rt_tuse,
    input  logic                   D_md_use,
    input  logic [4:0]             E_wa,
    input  logic                   E_regwrite,
    input  logic [1:0]             E_tnew,
    input  logic                   E_md_start,
    input  logic                   E_md_div,
    input  logic [4:0]             M_wa,
    input  logic                   M_regwrite,
    input  logic [1:0]             M_tnew,
    input  logic [4:0]             W_wa,
    input  logic                   W_regwrite,
    output logic                   stall,
    output logic                   pc_en,
    output logic                   if_id_en,
    output logic                   id_ex_clr,
    output logic [1:0]             fwd_rs_sel,
    output logic [1:0]             fwd_rt_sel,
    output logic                   md_busy,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    logic                   data_stall;
    logic                   md_stall;
    logic [STALL_CNT_W-1:0] stall_cycles_q;
    logic [STALL_CNT_W-1:0] stall_cycles_d;

    md_busy_counter #(
        .CNT_W    (CNT_W),
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC)
    ) u_md_busy_counter (
        .clk    (clk),
        .reset  (reset),
        .start  (E_md_start),
        .is_div (E_md_div),
        .busy   (md_busy)
    );

    // Stall decision: any source not deliverable from E or M in time, or a mult/div conflict.
    // An op issuing in E this cycle already occupies the unit, hence E_md_start in md_stall.
    always_comb begin
        data_stall = src_hazard(D_rs, D_rs_tuse, E_regwrite, E_wa, E_tnew)
                   | src_hazard(D_rs, D_rs_tuse, M_regwrite, M_wa, M_tnew)
                   | src_hazard(D_rt, D_rt_tuse, E_regwrite, E_wa, E_tnew)
                   | src_hazard(D_rt, D_rt_tuse, M_regwrite, M_wa, M_tnew);
        md_stall   = D_md_use & (md_busy | E_md_start);
        stall      = ~reset & (data_stall | md_stall);
        pc_en      = ~stall;
        if_id_en   = ~stall;
        id_ex_clr  = stall;
    end

    // Forward selects for both D sources, youngest ready producer first.
    always_comb begin
        fwd_rs_sel = fwd_pick(D_rs, E_regwrite, E_wa, E_tnew,
                              M_regwrite, M_wa, M_tnew, W_regwrite, W_wa);
        fwd_rt_sel = fwd_pick(D_rt, E_regwrite, E_wa, E_tnew,
                              M_regwrite, M_wa, M_tnew, W_regwrite, W_wa);
    end

    // Saturating stall counter: one increment per stalled cycle, sticks at all-ones.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 1'b1;
        end
    end

    // Stall counter register with synchronous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench: per-cycle reference model comparison plus directed literal checks.
// Latency: inputs driven 1 time unit after posedge, outputs sampled on negedge.
// Backpressure: n/a.
module tb_hazard_stall_ctrl;

    localparam int SMALL_W = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  D_rs, D_rt;
    logic [1:0]  D_rs_tuse, D_rt_tuse;
    logic        D_md_use;
    logic [4:0]  E_wa;
    logic        E_regwrite;
    logic [1:0]  E_tnew;
    logic        E_md_start, E_md_div;
    logic [4:0]  M_wa;
    logic        M_regwrite;
    logic [1:0]  M_tnew;
    logic [4:0]  W_wa;
    logic        W_regwrite;

    logic        stall, pc_en, if_id_en, id_ex_clr, md_busy;
    logic [1:0]  fwd_rs_sel, fwd_rt_sel;
    logic [31:0] stall_cycles;

    logic        stall_s, pc_en_s, if_id_en_s, id_ex_clr_s, md_busy_s;
    logic [1:0]  fwd_rs_sel_s, fwd_rt_sel_s;
    logic [SMALL_W-1:0] stall_cycles_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl dut (
        .clk(clk), .reset(reset),
        .D_rs(D_rs), .D_rt(D_rt), .D_rs_tuse(D_rs_tuse), .D_rt_tuse(D_rt_tuse),
        .D_md_use(D_md_use),
        .E_wa(E_wa), .E_regwrite(E_regwrite), .E_tnew(E_tnew),
        .E_md_start(E_md_start), .E_md_div(E_md_div),
        .M_wa(M_wa), .M_regwrite(M_regwrite), .M_tnew(M_tnew),
        .W_wa(W_wa), .W_regwrite(W_regwrite),
        .stall(stall), .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_clr(id_ex_clr),
        .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
        .md_busy(md_busy), .stall_cycles(stall_cycles)
    );

    // Narrow perf counter copy so saturation is reachable in a short run.
    hazard_stall_ctrl #(.STALL_CNT_W(SMALL_W)) dut_s (
        .clk(clk), .reset(reset),
        .D_rs(D_rs), .D_rt(D_rt), .D_rs_tuse(D_rs_tuse), .D_rt_tuse(D_rt_tuse),
        .D_md_use(D_md_use),
        .E_wa(E_wa), .E_regwrite(E_regwrite), .E_tnew(E_tnew),
        .E_md_start(E_md_start), .E_md_div(E_md_div),
        .M_wa(M_wa), .M_regwrite(M_regwrite), .M_tnew(M_tnew),
        .W_wa(W_wa), .W_regwrite(W_regwrite),
        .stall(stall_s), .pc_en(pc_en_s), .if_id_en(if_id_en_s), .id_ex_clr(id_ex_clr_s),
        .fwd_rs_sel(fwd_rs_sel_s), .fwd_rt_sel(fwd_rt_sel_s),
        .md_busy(md_busy_s), .stall_cycles(stall_cycles_s)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The mult/div unit is busy in the cycles strictly after the last start,
    // up to and including start + length. Reset forgets the last start.
    int    cyc        = 0;
    int    last_start = -1000;
    int    last_len   = 0;
    longint sc_model  = 0;
    bit    chk_en     = 0;

    function automatic bit m_busy();
        return (cyc > last_start) && (cyc <= last_start + last_len);
    endfunction

    function automatic bit m_src_stall(input logic [4:0] s, input logic [1:0] tuse);
        logic [4:0] wa [2];
        logic       we [2];
        int         tn [2];
        if (s == 0 || tuse == 3) return 0;
        wa[0] = E_wa; we[0] = E_regwrite; tn[0] = int'(E_tnew);
        wa[1] = M_wa; we[1] = M_regwrite; tn[1] = int'(M_tnew);
        for (int p = 0; p < 2; p++)
            if (we[p] && wa[p] == s && tn[p] > int'(tuse)) return 1;
        return 0;
    endfunction

    function automatic bit m_stall();
        if (reset) return 0;
        return m_src_stall(D_rs, D_rs_tuse) || m_src_stall(D_rt, D_rt_tuse)
            || (D_md_use && (m_busy() || E_md_start));
    endfunction

    // Stages listed youngest first; code = 3 - index. W is always ready.
    function automatic int m_fwd(input logic [4:0] s);
        logic [4:0] wa [3];
        logic       we [3];
        bit         rdy [3];
        if (s == 0) return 0;
        wa[0] = E_wa; we[0] = E_regwrite; rdy[0] = (E_tnew == 0);
        wa[1] = M_wa; we[1] = M_regwrite; rdy[1] = (M_tnew == 0);
        wa[2] = W_wa; we[2] = W_regwrite; rdy[2] = 1;
        for (int p = 0; p < 3; p++)
            if (we[p] && wa[p] == s && rdy[p]) return 3 - p;
        return 0;
    endfunction

    function automatic longint sat(input longint v, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // Model state advance at each clock edge.
    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                last_start = -1000;
                sc_model   = 0;
                chk_en     = 1;
            end else begin
                if (m_stall()) sc_model++;
                if (E_md_start) begin
                    last_start = cyc;
                    last_len   = E_md_div ? 10 : 5;
                end
            end
            cyc++;
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin
        bit es;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                es = m_stall();
                check("stall", stall, es);
                check("pc_en", pc_en, !es);
                check("if_id_en", if_id_en, !es);
                check("id_ex_clr", id_ex_clr, es);
                check("fwd_rs_sel", fwd_rs_sel, m_fwd(D_rs));
                check("fwd_rt_sel", fwd_rt_sel, m_fwd(D_rt));
                check("md_busy", md_busy, m_busy());
                check("stall_cycles", stall_cycles, sat(sc_model, 32));
                check("stall_cycles_small", stall_cycles_s, sat(sc_model, SMALL_W));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        D_rs = 0; D_rt = 0; D_rs_tuse = 3; D_rt_tuse = 3; D_md_use = 0;
        E_wa = 0; E_regwrite = 0; E_tnew = 0; E_md_start = 0; E_md_div = 0;
        M_wa = 0; M_regwrite = 0; M_tnew = 0; W_wa = 0; W_regwrite = 0;
    endtask

    task automatic set_load_use();
        E_wa = 8; E_tnew = 2; E_regwrite = 1; D_rs = 8; D_rs_tuse = 1;
    endtask

    initial begin
        clear_inputs();
        reset = 1;
        step();
        // Hazard present while reset is held: stall must stay low.
        set_load_use();
        D_md_use = 1; E_md_start = 1;
        @(negedge clk);
        check("rst_stall", stall, 0);
        check("rst_pc_en", pc_en, 1);
        check("rst_id_ex_clr", id_ex_clr, 0);
        check("rst_md_busy", md_busy, 0);
        check("rst_stall_cycles", stall_cycles, 0);
        step();
        clear_inputs();
        reset = 0;

        // Load-use from E.
        set_load_use();
        @(negedge clk);
        check("lu_stall", stall, 1);
        check("lu_pc_en", pc_en, 0);
        check("lu_if_id_en", if_id_en, 0);
        check("lu_id_ex_clr", id_ex_clr, 1);
        step();

        // Same producer now in M, not yet ready, but D needs it one cycle later.
        clear_inputs();
        M_wa = 8; M_tnew = 1; M_regwrite = 1; D_rs = 8; D_rs_tuse = 1;
        @(negedge clk);
        check("m_stall", stall, 0);
        check("m_fwd_rs", fwd_rs_sel, 0);
        check("m_stall_cycles", stall_cycles, 1);
        step();
        M_tnew = 0;
        @(negedge clk);
        check("m_fwd_rs_ready", fwd_rs_sel, 2);
        step();

        // $0 never hazards/forwards; an unread rt never stalls.
        clear_inputs();
        E_wa = 0; E_regwrite = 1; E_tnew = 2; D_rs = 0; D_rs_tuse = 0;
        @(negedge clk);
        check("zero_stall", stall, 0);
        check("zero_fwd", fwd_rs_sel, 0);
        step();
        E_wa = 9; D_rt = 9; D_rt_tuse = 3;
        @(negedge clk);
        check("unused_rt_stall", stall, 0);
        step();

        // Forward priority E > M > W.
        clear_inputs();
        E_wa = 5; E_regwrite = 1; M_wa = 5; M_regwrite = 1; W_wa = 5; W_regwrite = 1;
        D_rt = 5; D_rt_tuse = 0;
        @(negedge clk);
        check("prio_e", fwd_rt_sel, 3);
        step();
        E_regwrite = 0;
        @(negedge clk);
        check("prio_m", fwd_rt_sel, 2);
        step();
        M_regwrite = 0;
        @(negedge clk);
        check("prio_w", fwd_rt_sel, 1);
        step();

        // Divide with D waiting on the unit; counter freshly cleared.
        clear_inputs();
        reset = 1;
        step();
        reset = 0;
        E_md_start = 1; E_md_div = 1; D_md_use = 1;
        @(negedge clk);
        check("div_t_stall", stall, 1);
        check("div_t_busy", md_busy, 0);
        step();
        E_md_start = 0;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            check($sformatf("div_busy_%0d", k), md_busy, (k <= 10));
            check($sformatf("div_stall_%0d", k), stall, (k <= 10));
            step();
        end
        @(negedge clk);
        check("div_stall_cycles", stall_cycles, 11);

        // Reset in the middle of a mult.
        clear_inputs();
        E_md_start = 1;
        step();
        E_md_start = 0;
        step();
        step();
        reset = 1;
        step();
        reset = 0;
        D_md_use = 1;
        @(negedge clk);
        check("mrst_busy", md_busy, 0);
        check("mrst_stall", stall, 0);
        check("mrst_stall_cycles", stall_cycles, 0);
        step();

        // Hold a stall long enough to saturate the narrow counter.
        clear_inputs();
        set_load_use();
        repeat (40) step();
        @(negedge clk);
        check("sat_full", stall_cycles, 40);
        check("sat_small", stall_cycles_s, 31);
        step();

        // Randomized traffic over a small register set to provoke hits.
        for (int i = 0; i < 3000; i++) begin
            reset      = ($urandom_range(0, 99) == 0);
            D_rs       = 5'($urandom_range(0, 3));
            D_rt       = 5'($urandom_range(0, 3));
            D_rs_tuse  = 2'($urandom_range(0, 3));
            D_rt_tuse  = 2'($urandom_range(0, 3));
            D_md_use   = ($urandom_range(0, 3) == 0);
            E_wa       = 5'($urandom_range(0, 3));
            E_regwrite = 1'($urandom_range(0, 1));
            E_tnew     = 2'($urandom_range(0, 3));
            E_md_start = ($urandom_range(0, 7) == 0);
            E_md_div   = 1'($urandom_range(0, 1));
            M_wa       = 5'($urandom_range(0, 3));
            M_regwrite = 1'($urandom_range(0, 1));
            M_tnew     = 2'($urandom_range(0, 3));
            W_wa       = 5'($urandom_range(0, 3));
            W_regwrite = 1'($urandom_range(0, 1));
            step();
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
